ramp_sequencer: RTL and testbench
=================================

RAMP_SEQUENCER -- requirements
Module: ramp_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: counter and endpoint width in bits.
REQ-002 Parameter DWELL_W, default 4: dwell field width in bits.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_start  input  WIDTH  ramp start value.
REQ-008 cmd_end  input  WIDTH  ramp end value.
REQ-009 cmd_dwell  input  DWELL_W  extra hold cycles at end value.
REQ-010 abort  input  1  terminate the active ramp.
REQ-011 count  output  WIDTH  current counter value.
REQ-012 dir  output  1  direction of the active ramp: 0 up, 1 down.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 aborted  output  1  one-cycle pulse on abort.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN, DWELL and DONE.
REQ-017 cmd_ready SHALL equal (state==IDLE), and busy SHALL equal its inverse.
REQ-018 Handshake: in IDLE with cmd_valid=1, latch cmd_start, cmd_end and cmd_dwell; set dir = (cmd_end < cmd_start), unsigned; go to LOAD.
REQ-019 cmd_* SHALL be ignored while cmd_ready=0; latched values stay fixed for the whole ramp.
REQ-020 LOAD: load the counter with the latched start value; go to RUN.
REQ-021 RUN with count != end: step the counter by exactly 1 toward end; remain in RUN.
REQ-022 RUN with count == end: no step; load the dwell counter with the latched dwell; go to DWELL.
REQ-023 DWELL: if the dwell counter is 0, go to DONE; otherwise decrement it; count holds.
REQ-024 DONE: done=1 for this cycle only; go to IDLE.
REQ-025 Latency: done SHALL be high in the cycle after the (3 + |end-start| + dwell)th rising edge following the accept edge.
REQ-026 The sequencer SHALL never drive the counter past end, so count never wraps modulo 2^WIDTH.
REQ-027 count SHALL hold its value in IDLE, including after a completed or aborted ramp.
REQ-028 abort=1 in LOAD, RUN or DWELL: go to IDLE at the next edge and pulse aborted=1 for one cycle. count holds the value it has at that edge, and done is not asserted.
REQ-029 abort=1 in DONE: done still pulses that cycle, and aborted is not asserted.
REQ-030 abort=1 in IDLE: no effect; a simultaneous cmd_valid is still accepted.
REQ-031 done and aborted SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n=0, regardless of clk: state=IDLE, count=0, dir=0, done=0, aborted=0, busy=0, cmd_ready=1, and latched fields=0.
REQ-033 Reset asserted mid-ramp SHALL discard the ramp without producing a done or aborted pulse.

Structure
REQ-034 Package ramp_seq_pkg SHALL hold the FSM state enum typedef and the default WIDTH/DWELL_W constants.
REQ-035 The counter SHALL be a sub-module ramp_counter_core with ports clk, rst_n, enable, up_down, load, data_in and count.
REQ-036 ramp_counter_core SHALL be a synchronous load/step counter with asynchronous reset to 0; it changes only when enabled, and load takes priority over step.
REQ-037 The sequencer SHALL contain the FSM, the latched command and the dwell counter; it SHALL contain no second arithmetic counter for count.

Verification
REQ-038 start=2, end=5, dwell=0 -> count 2,3,4,5; dir=0; done at accept+6 edges.
REQ-039 start=9, end=3, dwell=2 -> dir=1; count 9 down to 3; count holds 3 for 3 DWELL cycles; done at accept+11.
REQ-040 start=7, end=7, dwell=0 -> count=7; done at accept+3; cmd_ready returns 1 the next cycle.
REQ-041 Ramp 0->15 with abort pulsed when count=4 -> IDLE next edge; count stays 4; aborted pulses once; no done.
REQ-042 cmd_valid held high with two commands (1->3, then 3->0) -> second command accepted in the first IDLE cycle after DONE; commands presented while busy are ignored.
REQ-043 rst_n driven low mid-RUN between clock edges -> all outputs take REQ-032 values immediately; no done or aborted pulse follows.

Source files
------------

// File: rtl/ramp_seq_pkg.sv
// ramp_seq_pkg: shared definitions for the ramp sequencer.
//   state_t      - sequencer FSM state encoding
//   DEF_WIDTH    - default counter / endpoint width
//   DEF_DWELL_W  - default dwell field width
package ramp_seq_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_DWELL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DWELL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ramp_counter_core.sv
// ramp_counter_core: load/step up-down counter.
//   clk, rst_n - clock, asynchronous active-low reset (count -> 0)
//   enable     - counter changes only when high
//   up_down    - step direction: 0 increment, 1 decrement
//   load       - load data_in (has priority over stepping)
//   data_in    - value to load
//   count      - current counter value
module ramp_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable) begin
      if (load)         count <= data_in;
      else if (up_down) count <= count - 1'b1;
      else              count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: accepts a ramp command (start, end, dwell), steps the
// counter from start to end one unit per cycle, holds end for dwell extra
// cycles, then pulses done. abort returns to IDLE with an aborted pulse.
//   clk, rst_n                     - clock, asynchronous active-low reset
//   cmd_valid / cmd_ready          - command handshake (ready only in IDLE)
//   cmd_start, cmd_end, cmd_dwell  - command fields, latched on accept
//   abort                          - terminate the active ramp
//   count                          - counter value (held in IDLE)
//   dir                            - ramp direction, 0 up / 1 down
//   busy                           - high outside IDLE
//   done, aborted                  - one-cycle completion / abort pulses
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for a command; count holds
// ST_LOAD  | counter loads the latched start value
// ST_RUN   | stepping toward end; leaves when count == end
// ST_DWELL | holding end while the dwell counter runs down
// ST_DONE  | done pulse cycle, returns to IDLE
module ramp_sequencer
  import ramp_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_start,
  input  logic [WIDTH-1:0]   cmd_end,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  state_t             state;
  logic [WIDTH-1:0]   start_q;
  logic [WIDTH-1:0]   end_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               at_end;
  logic               cnt_load;
  logic               cnt_en;

  assign at_end    = (count == end_q);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;

  // Counter is gated off on an abort edge so count freezes at the value it
  // had when abort was sampled; stepping stops exactly at end, so no wrap.
  assign cnt_load = (state == ST_LOAD) && !abort;
  assign cnt_en   = cnt_load || ((state == ST_RUN) && !abort && !at_end);

  ramp_counter_core #(.WIDTH(WIDTH)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (cnt_en),
    .up_down (dir),
    .load    (cnt_load),
    .data_in (start_q),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_q   <= '0;
      end_q     <= '0;
      dwell_q   <= '0;
      dwell_cnt <= '0;
      dir       <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            start_q <= cmd_start;
            end_q   <= cmd_end;
            dwell_q <= cmd_dwell;
            dir     <= (cmd_end < cmd_start);
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else if (at_end) begin
            dwell_cnt <= dwell_q;
            state     <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else if (dwell_cnt == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: randomized and directed stimulus for ramp_sequencer,
// compared cycle by cycle against an arithmetic model of a ramp:
// index j counts cycles after the accept edge; j=0 shows the old count,
// j=1..|d|+1 show start +/- (j-1), then end until done at j=3+|d|+dwell.
module tb_ramp_sequencer;

  localparam int WIDTH   = 4;
  localparam int DWELL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_start;
  logic [WIDTH-1:0]   cmd_end;
  logic [DWELL_W-1:0] cmd_dwell;
  logic               abort;
  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               busy;
  logic               done;
  logic               aborted;

  int n_chk = 0;
  int n_err = 0;
  int c0    = 0;   // model of count while idle
  int e_dir = 0;   // model of dir while idle

  ramp_sequencer #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_dwell (cmd_dwell),
    .abort     (abort),
    .count     (count),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int j, input int s, input int e,
                                 input int d, input int prev);
    if (j == 0)     return prev;
    if (j <= d + 1) return (e < s) ? s - (j - 1) : s + (j - 1);
    return e;
  endfunction

  task automatic check_idle(input int ec, input int ab);
    check("idle_count",   int'(count),     ec);
    check("idle_busy",    int'(busy),      0);
    check("idle_ready",   int'(cmd_ready), 1);
    check("idle_done",    int'(done),      0);
    check("idle_aborted", int'(aborted),   ab);
    check("idle_dir",     int'(dir),       e_dir);
  endtask

  // Called in an idle cycle (1 time unit after an edge); returns in the
  // first idle cycle after the ramp, so calls chain back to back.
  // ja >= 0 asserts abort during cycle index ja.
  task automatic run_cmd(input int s, input int e, input int dw, input int ja);
    int d, didx, last, ec;
    d    = (e >= s) ? e - s : s - e;
    didx = 3 + d + dw;
    last = (ja >= 0 && ja < didx) ? ja : didx;
    cmd_valid = 1'b1;
    cmd_start = 4'(s);
    cmd_end   = 4'(e);
    cmd_dwell = 4'(dw);
    abort     = 1'($urandom_range(0, 1));   // abort in IDLE has no effect
    @(posedge clk); #1;
    e_dir = (e < s) ? 1 : 0;
    for (int j = 0; j <= last; j++) begin
      check("count",   int'(count),   exp_cnt(j, s, e, d, c0));
      check("busy",    int'(busy),    1);
      check("ready",   int'(cmd_ready), 0);
      check("done",    int'(done),    (j == didx) ? 1 : 0);
      check("aborted", int'(aborted), 0);
      check("dir",     int'(dir),     e_dir);
      abort     = (j == ja) ? 1'b1 : 1'b0;
      // Garbage commands while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_start = 4'($urandom_range(0, 15));
      cmd_end   = 4'($urandom_range(0, 15));
      cmd_dwell = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    ec = (last < didx) ? exp_cnt(last, s, e, d, c0) : e;
    check_idle(ec, (last < didx) ? 1 : 0);
    c0        = ec;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    int s, e, dw, ja, d;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_end   = '0;
    cmd_dwell = '0;
    abort     = 1'b0;
    #2;
    check_idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle(0, 0);

    // Directed ramps
    run_cmd(2, 5, 0, -1);
    run_cmd(9, 3, 2, -1);
    run_cmd(7, 7, 0, -1);
    run_cmd(0, 15, 0, 5);      // abort observed while count == 4
    run_cmd(1, 3, 0, -1);      // back-to-back pair with cmd_valid held
    run_cmd(3, 0, 0, -1);
    run_cmd(4, 6, 1, 6);       // abort during DONE: done still pulses
    run_cmd(15, 0, 0, -1);
    run_cmd(5, 9, 3, 0);       // abort during LOAD

    // Randomized ramps
    for (int k = 0; k < 40; k++) begin
      s  = $urandom_range(0, 15);
      e  = $urandom_range(0, 15);
      dw = $urandom_range(0, 6);
      d  = (e >= s) ? e - s : s - e;
      ja = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3 + d + dw) : -1;
      run_cmd(s, e, dw, ja);
    end

    // Reset mid-RUN, asserted between edges
    cmd_valid = 1'b1;
    cmd_start = 4'd0;
    cmd_end   = 4'd15;
    cmd_dwell = 4'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    e_dir = 0;
    check_idle(0, 0);
    @(posedge clk); #1;
    check_idle(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check_idle(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
